// File: rtl/mult_nin_seq.sv
// Sequential N-operand signed fixed-point product: one WIDTHxWIDTH multiply per clock, rounded every step.
// Define MULT_NIN_SAT_EN to clamp overflowing steps instead of wrapping them.
module mult_nin_seq #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 24,
   parameter int NIN   = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NIN*WIDTH-1:0]   i_op,
   input  logic                   i_valid,
   output logic                   o_ready,
   output logic [WIDTH-1:0]       o,
   output logic                   o_ovf,
   output logic                   o_valid,
   input  logic                   i_ready
);

   localparam int PW = 2 * WIDTH;
   localparam int KW = (NIN > 1) ? $clog2(NIN) : 1;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   // Rescale by FRAC with round-half-up on the first discarded bit.
   function automatic logic signed [PW-1:0] round_step(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] sh;
      logic signed [PW-1:0] half;
      sh   = p >>> FRAC;
      half = $signed({{(PW-1){1'b0}}, p[FRAC-1]});
      return sh + half;
   endfunction

   function automatic logic fits_w(input logic signed [PW-1:0] r);
      return r[PW-1:WIDTH-1] == {(PW-WIDTH+1){r[WIDTH-1]}};
   endfunction

   function automatic logic signed [WIDTH-1:0] limit_w(input logic signed [PW-1:0] r);
`ifdef MULT_NIN_SAT_EN
      if (fits_w(r))
         return r[WIDTH-1:0];
      else if (r[PW-1])
         return {1'b1, {(WIDTH-1){1'b0}}};
      else
         return {1'b0, {(WIDTH-1){1'b1}}};
`else
      return r[WIDTH-1:0];
`endif
   endfunction

   state_t                   state_q, state_d;
   logic signed [WIDTH-1:0]  acc_q, acc_d;
   logic [NIN*WIDTH-1:0]     op_q, op_d;
   logic [KW-1:0]            k_q, k_d;
   logic                     ovf_q, ovf_d;
   logic [WIDTH-1:0]         o_q, o_d;
   logic                     o_ovf_q, o_ovf_d;

   logic signed [WIDTH-1:0]  op_sel;
   logic signed [PW-1:0]     prod;
   logic signed [PW-1:0]     step_r;
   logic                     step_ovf;
   logic signed [WIDTH-1:0]  step_acc;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      op_d     = op_q;
      k_d      = k_q;
      ovf_d    = ovf_q;
      o_d      = o_q;
      o_ovf_d  = o_ovf_q;
      op_sel   = op_q[int'(k_q)*WIDTH +: WIDTH];
      prod     = PW'(acc_q) * PW'(op_sel);
      step_r   = round_step(prod);
      step_ovf = ~fits_w(step_r);
      step_acc = limit_w(step_r);
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               acc_d = i_op[WIDTH-1:0];
               op_d  = i_op;
               k_d   = KW'(1);
               ovf_d = 1'b0;
               if (NIN == 1) begin
                  o_d     = i_op[WIDTH-1:0];
                  o_ovf_d = 1'b0;
                  state_d = DONE;
               end else begin
                  state_d = MUL;
               end
            end
         end
         MUL: begin
            // The last operand writes straight to the output register.
            if (k_q == KW'(NIN - 1)) begin
               o_d     = step_acc;
               o_ovf_d = ovf_q | step_ovf;
               state_d = DONE;
            end else begin
               acc_d = step_acc;
               ovf_d = ovf_q | step_ovf;
               k_d   = k_q + KW'(1);
            end
         end
         DONE: begin
            if (i_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         o_q     <= '0;
         o_ovf_q <= 1'b0;
      end else begin
         state_q <= state_d;
         o_q     <= o_d;
         o_ovf_q <= o_ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      acc_q <= acc_d;
      op_q  <= op_d;
      k_q   <= k_d;
      ovf_q <= ovf_d;
   end

   assign o_ready = (state_q == IDLE);
   assign o_valid = (state_q == DONE);
   assign o       = o_q;
   assign o_ovf   = o_ovf_q;

endmodule

// File: tb/tb_mult_nin_seq.sv
// Bench for mult_nin_seq: NIN=3 unit checked every cycle against a transaction-level model, plus NIN=1 and NIN=5 units.
module tb_mult_nin_seq;

   typedef logic [31:0] vec_t [8];

   logic          clk = 1'b0;
   logic          rst;
   logic [95:0]   i_op;
   logic          i_valid, i_ready;
   logic          o_ready, o_valid, o_ovf;
   logic [31:0]   o;

   logic [31:0]   op1;
   logic          v1, rdy1, val1, ovf1;
   logic [31:0]   o1;
   logic [159:0]  op5;
   logic          v5, rdy5, val5, ovf5;
   logic [31:0]   o5;
   logic          one = 1'b1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mult_nin_seq #(.WIDTH(32), .FRAC(24), .NIN(3)) dut (
      .clk(clk), .rst(rst), .i_op(i_op), .i_valid(i_valid), .o_ready(o_ready),
      .o(o), .o_ovf(o_ovf), .o_valid(o_valid), .i_ready(i_ready));

   mult_nin_seq #(.WIDTH(32), .FRAC(24), .NIN(1)) dut1 (
      .clk(clk), .rst(rst), .i_op(op1), .i_valid(v1), .o_ready(rdy1),
      .o(o1), .o_ovf(ovf1), .o_valid(val1), .i_ready(one));

   mult_nin_seq #(.WIDTH(32), .FRAC(24), .NIN(5)) dut5 (
      .clk(clk), .rst(rst), .i_op(op5), .i_valid(v5), .o_ready(rdy5),
      .o(o5), .o_ovf(ovf5), .o_valid(val5), .i_ready(one));

   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -64'sd2147483648;

   // Reference product with per-step rounding in plain 64-bit arithmetic; returns {ovf, result}.
   function automatic logic [32:0] ref_prod(input int n, input vec_t v);
      longint acc, p, r;
      logic   ovf;
      acc = longint'($signed(v[0]));
      ovf = 1'b0;
      for (int k = 1; k < n; k++) begin
         p = acc * longint'($signed(v[k]));
         r = (p >>> 24) + ((p >> 23) & 64'sd1);
         if (r > MAXV || r < MINV) begin
            ovf = 1'b1;
`ifdef MULT_NIN_SAT_EN
            acc = (r > 0) ? MAXV : MINV;
`else
            acc = longint'($signed(r[31:0]));
`endif
         end else begin
            acc = r;
         end
      end
      return {ovf, acc[31:0]};
   endfunction

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                               input logic [31:0] d, input logic [31:0] e);
      vec_t v;
      for (int i = 0; i < 8; i++) v[i] = '0;
      v[0] = a; v[1] = b; v[2] = c; v[3] = d; v[4] = e;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // Transaction-level model of the NIN=3 unit's externally visible behaviour.
   logic [32:0] cur;
   always_comb begin
      vec_t v;
      for (int i = 0; i < 8; i++) v[i] = '0;
      for (int i = 0; i < 3; i++) v[i] = i_op[i*32 +: 32];
      cur = ref_prod(3, v);
   end

   logic        m_init = 1'b0;
   logic        m_ready, m_valid, m_ovf;
   logic [31:0] m_o;
   logic [32:0] m_pend;
   int          m_cnt;

   always @(posedge clk) begin
      if (rst) begin
         m_init  <= 1'b1;
         m_ready <= 1'b1;
         m_valid <= 1'b0;
         m_o     <= '0;
         m_ovf   <= 1'b0;
         m_cnt   <= 0;
      end else if (m_ready) begin
         if (i_valid) begin
            m_ready <= 1'b0;
            m_cnt   <= 2;
            m_pend  <= cur;
         end
      end else if (!m_valid) begin
         if (m_cnt == 1) begin
            m_valid <= 1'b1;
            m_ovf   <= m_pend[32];
            m_o     <= m_pend[31:0];
         end
         m_cnt <= m_cnt - 1;
      end else if (i_ready) begin
         m_valid <= 1'b0;
         m_ready <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("o_ready", 32'(o_ready), 32'(m_ready));
         chk("o_valid", 32'(o_valid), 32'(m_valid));
         chk("o", o, m_o);
         chk("o_ovf", 32'(o_ovf), 32'(m_ovf));
      end
   end

   function automatic logic [95:0] pack3(input vec_t v);
      return {v[2], v[1], v[0]};
   endfunction

   task automatic xact3(input vec_t v, input int hold, input logic chk_lit,
                        input logic [31:0] lit, input logic lit_ovf);
      int n;
      i_op    = pack3(v);
      i_ready = (hold == 0);
      i_valid = 1'b1;
      n = 0;
      while (!o_ready && n < 50) begin @(negedge clk); n++; end
      chk("accept_wait", 32'(n >= 50), 32'd0);
      @(posedge clk);
      @(negedge clk);
      i_valid = 1'b0;
      n = 0;
      while (!o_valid && n < 50) begin @(negedge clk); n++; end
      chk("latency3", 32'(n), 32'd2);
      if (chk_lit) begin
         chk("lit_o", o, lit);
         chk("lit_ovf", 32'(o_ovf), 32'(lit_ovf));
      end
      for (int h = 0; h < hold; h++) begin
         i_valid = 1'b1;
         i_op    = {$urandom, $urandom, $urandom};
         @(negedge clk);
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic xact1(input logic [31:0] a);
      int n;
      op1 = a;
      v1  = 1'b1;
      n = 0;
      while (!rdy1 && n < 50) begin @(negedge clk); n++; end
      chk("accept_wait1", 32'(n >= 50), 32'd0);
      @(posedge clk);
      @(negedge clk);
      v1 = 1'b0;
      n = 0;
      while (!val1 && n < 50) begin @(negedge clk); n++; end
      chk("latency1", 32'(n), 32'd0);
      chk("o_nin1", o1, a);
      chk("ovf_nin1", 32'(ovf1), 32'd0);
      @(negedge clk);
   endtask

   task automatic xact5(input vec_t v, input logic chk_lit, input logic [31:0] lit);
      int n;
      logic [32:0] e;
      e   = ref_prod(5, v);
      op5 = {v[4], v[3], v[2], v[1], v[0]};
      v5  = 1'b1;
      n = 0;
      while (!rdy5 && n < 50) begin @(negedge clk); n++; end
      chk("accept_wait5", 32'(n >= 50), 32'd0);
      @(posedge clk);
      @(negedge clk);
      v5 = 1'b0;
      n = 0;
      while (!val5 && n < 50) begin @(negedge clk); n++; end
      chk("latency5", 32'(n), 32'd4);
      chk("o_nin5", o5, e[31:0]);
      chk("ovf_nin5", 32'(ovf5), 32'(e[32]));
      if (chk_lit) chk("lit_nin5", o5, lit);
      @(negedge clk);
   endtask

   function automatic logic [31:0] rnd_small(input int mag);
      return $urandom_range(0, 2 * mag) - mag;
   endfunction

   logic [32:0] pr;
   logic [31:0] ovf_lit;
   vec_t        rv;

   initial begin
      rst = 1'b1; i_op = '0; i_valid = 1'b0; i_ready = 1'b0;
      op1 = '0; v1 = 1'b0; op5 = '0; v5 = 1'b0;
`ifdef MULT_NIN_SAT_EN
      ovf_lit = 32'h7FFFFFFF;
`else
      ovf_lit = 32'h00000000;
`endif
      repeat (3) @(negedge clk);
      rst = 1'b0;

      pr = ref_prod(3, mk(32'h02000000, 32'h03000000, 32'h00800000, 0, 0));
      chk("model_basic", pr[31:0], 32'h03000000);
      pr = ref_prod(3, mk(32'h00000001, 32'h00800000, 32'h01000000, 0, 0));
      chk("model_round_up", pr[31:0], 32'h00000001);
      pr = ref_prod(3, mk(32'hFFFFFFFF, 32'h00800000, 32'h01000000, 0, 0));
      chk("model_round_neg", pr[31:0], 32'h00000000);
      pr = ref_prod(3, mk(32'h10000000, 32'h10000000, 32'h01000000, 0, 0));
      chk("model_ovf", pr[31:0], ovf_lit);
      chk("model_ovf_flag", 32'(pr[32]), 32'd1);
      pr = ref_prod(5, mk(32'h01000000, 32'h01000000, 32'hFE000000, 32'h01000000, 32'h01000000));
      chk("model_nin5", pr[31:0], 32'hFE000000);

      xact3(mk(32'h02000000, 32'h03000000, 32'h00800000, 0, 0), 0, 1'b1, 32'h03000000, 1'b0);
      xact3(mk(32'h00000001, 32'h00800000, 32'h01000000, 0, 0), 0, 1'b1, 32'h00000001, 1'b0);
      xact3(mk(32'hFFFFFFFF, 32'h00800000, 32'h01000000, 0, 0), 0, 1'b1, 32'h00000000, 1'b0);
      xact3(mk(32'h10000000, 32'h10000000, 32'h01000000, 0, 0), 0, 1'b1, ovf_lit, 1'b1);
      xact3(mk(32'h01800000, 32'h02000000, 32'h01000000, 0, 0), 5, 1'b1, 32'h03000000, 1'b0);

      // Reset one edge into the multiply phase; the transaction must vanish.
      i_op    = pack3(mk(32'h05000000, 32'h03000000, 32'h02000000, 0, 0));
      i_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_valid = 1'b0;
      rst     = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_o", o, 32'd0);
      repeat (3) @(negedge clk);
      chk("rst_no_result", 32'(o_valid), 32'd0);
      xact3(mk(32'h02000000, 32'h03000000, 32'h00800000, 0, 0), 0, 1'b1, 32'h03000000, 1'b0);

      xact1(32'hFF000000);
      xact5(mk(32'h01000000, 32'h01000000, 32'hFE000000, 32'h01000000, 32'h01000000), 1'b1, 32'hFE000000);

      for (int t = 0; t < 150; t++) begin
         for (int i = 0; i < 8; i++) rv[i] = '0;
         for (int i = 0; i < 3; i++)
            rv[i] = ($urandom_range(0, 1) == 0) ? rnd_small(32'h04000000) : $urandom;
         xact3(rv, $urandom_range(0, 3), 1'b0, 32'd0, 1'b0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < 8; i++) rv[i] = '0;
         for (int i = 0; i < 5; i++) rv[i] = rnd_small(32'h02000000);
         xact5(rv, 1'b0, 32'd0);
         xact1($urandom);
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
